neg_not_seq_32: RTL and testbench

- Multi-cycle complement unit for the datapath ALU.
- Produces either the bitwise NOT or the two's-complement negation (NOT + 1) of a 32-bit operand.
- Processes DIGIT bits per clock, with a ripple carry held in a register between digits.
- Sits beside the combinational logic unit. The control unit drives start/op and captures z into the Z register when done pulses.

---
 rtl/neg_not_seq_32_pkg.sv | 20 ++
 rtl/neg_not_seq_32_if.sv | 37 +++
 rtl/neg_not_seq_32_digit.sv | 20 ++
 rtl/neg_not_seq_32.sv | 120 ++++++++++++
 tb/tb_neg_not_seq_32.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/neg_not_seq_32_pkg.sv
// Shared ALU definitions for the sequential complement unit: op codes, FSM state
// encodings and default datapath geometry.
package neg_not_seq_32_pkg;

  localparam logic OP_NOT = 1'b0;
  localparam logic OP_NEG = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

  // Number of RUN cycles for a given geometry.
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/neg_not_seq_32_if.sv
// Request/result bundle between the control unit (master) and the complement unit (slave).
// Optional ovf wire is present only when NEG_NOT_SEQ_OVF_EN is defined.
//
// Handshake: the slave samples start only in IDLE; op/a are captured on that edge and
// may change afterwards. done is a one-cycle pulse, and z/zero (and ovf) are valid
// from that pulse until the next accepted start. busy is high for every RUN cycle.
interface neg_not_seq_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             zero;
`ifdef NEG_NOT_SEQ_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, op, a,
`ifdef NEG_NOT_SEQ_OVF_EN
    input  ovf,
`endif
    input  busy, done, z, zero
  );

  modport slave (
    input  start, op, a,
`ifdef NEG_NOT_SEQ_OVF_EN
    output ovf,
`endif
    output busy, done, z, zero
  );

endinterface

// File: rtl/neg_not_seq_32_digit.sv
// Combinational DIGIT-bit slice: sum = ~d + cin, with the carry out of the slice.
module neg_not_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] d,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, ~d} + {{DIGIT{1'b0}}, cin};
  end

  assign sum  = full[DIGIT-1:0];
  assign cout = full[DIGIT];

endmodule

// File: rtl/neg_not_seq_32.sv
// Multi-cycle NOT / two's-complement negate, DIGIT bits per cycle with a registered
// ripple carry. Optional ovf output enabled by NEG_NOT_SEQ_OVF_EN.
module neg_not_seq_32
  import neg_not_seq_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic              clk,
  input  logic              rst_n,
  neg_not_seq_32_if.slave   bus,
  output logic [1:0]        state_dbg
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] z_next;
  logic             zero_q;
  logic             done_q;

  logic [DIGIT-1:0] dig_in;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;

  always_comb begin
    dig_in = opnd[count*DIGIT +: DIGIT];
  end

  neg_not_digit #(.DIGIT(DIGIT)) u_digit (
    .d    (dig_in),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // Full result including the digit being written this cycle, so zero sees all bits.
  always_comb begin
    z_next = z_q;
    z_next[count*DIGIT +: DIGIT] = dig_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      carry  <= 1'b0;
      opnd   <= '0;
      z_q    <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opnd  <= bus.a;
            carry <= bus.op;
            count <= '0;
            z_q   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          z_q   <= z_next;
          carry <= dig_cout;
          count <= count + 1'b1;
          if (count == LAST) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            zero_q <= (z_next == '0);
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NEG_NOT_SEQ_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic op_q;
  logic ovf_q;

  // Only negation of the most-negative operand overflows; NOT never does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_NOT;
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      op_q  <= bus.op;
      ovf_q <= 1'b0;
    end else if (state == ST_RUN && count == LAST) begin
      ovf_q <= (op_q == OP_NEG) && (opnd == MOST_NEG);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state == ST_RUN);
  assign bus.done = done_q;
  assign bus.z    = z_q;
  assign bus.zero = zero_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_neg_not_seq_32.sv
// Scoreboarded bench for neg_not_seq_32: directed corner cases plus random operands
// checked against a plain-arithmetic reference (~a or -a).
module tb_neg_not_seq_32;
  import neg_not_seq_32_pkg::*;

  localparam int W = 32;
  localparam int N = W / DEF_DIGIT;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;
  int         cyc;
  logic       prev_done;

  logic [33:0] exp_q[$];

  neg_not_seq_32_if #(.WIDTH(W)) bus ();

  neg_not_seq_32 #(.WIDTH(W), .DIGIT(DEF_DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [33:0] model(input logic [31:0] av, input logic opv);
    logic [31:0] r;
    logic        ovf;
    r   = opv ? 32'(-av) : ~av;
    ovf = opv && (av == 32'h8000_0000);
    return {ovf, (r == 32'd0), r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      logic [33:0] e;
      check("done_width", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("z", {32'd0, bus.z}, {32'd0, e[31:0]});
        check("zero", {63'd0, bus.zero}, {63'd0, e[32]});
`ifdef NEG_NOT_SEQ_OVF_EN
        check("ovf", {63'd0, bus.ovf}, {63'd0, e[33]});
`endif
      end
    end
    prev_done = bus.done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_op(input logic [31:0] av, input logic opv);
    int n;
    wait_idle();
    bus.a     = av;
    bus.op    = opv;
    bus.start = 1'b1;
    exp_q.push_back(model(av, opv));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.op    = 1'($urandom_range(0, 1));
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(N));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    int busy_falls;
    int n;
    int t[3];
    logic pb;
    logic [31:0] av;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;

    #12;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_z", {32'd0, bus.z}, 64'd0);
    check("rst_zero", {63'd0, bus.zero}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
`ifdef NEG_NOT_SEQ_OVF_EN
    check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // NOT corners, NEG carry paths, most-negative value
    do_op(32'h0000_0000, OP_NOT);
    do_op(32'hFFFF_FFFF, OP_NOT);
    do_op(32'h0000_0001, OP_NEG);
    do_op(32'hFFFF_FFFC, OP_NEG);
    do_op(32'h0000_0000, OP_NEG);
    do_op(32'h8000_0000, OP_NEG);
    do_op(32'h0000_000F, OP_NEG);

    // start pulsed again mid-RUN must be ignored
    wait_idle();
    bus.a = 32'h0000_000F; bus.op = OP_NOT; bus.start = 1'b1;
    exp_q.push_back(model(32'h0000_000F, OP_NOT));
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.a = 32'h5; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    done_cnt = 0; busy_falls = 0; pb = bus.busy;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (pb && !bus.busy) busy_falls++;
      pb = bus.busy;
    end
    check("busy_prot_dones", 64'(done_cnt), 64'd1);
    check("busy_prot_falls", 64'(busy_falls), 64'd1);

    // asynchronous reset mid-operation
    wait_idle();
    bus.a = 32'h1234_5678; bus.op = OP_NEG; bus.start = 1'b1;
    exp_q.push_back(model(32'h1234_5678, OP_NEG));
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_z", {32'd0, bus.z}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    do_op(32'h1234_5678, OP_NEG);

    // back-to-back with start held high
    wait_idle();
    av = $urandom;
    bus.a = av; bus.op = OP_NEG; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(av, OP_NEG));
    done_cnt = 0; n = 0;
    while (done_cnt < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        t[done_cnt] = cyc;
        done_cnt++;
      end
    end
    bus.start = 1'b0;
    check("b2b_dones", 64'(done_cnt), 64'd3);
    if (done_cnt == 3) begin
      check("b2b_period1", 64'(t[1] - t[0]), 64'(N + 2));
      check("b2b_period2", 64'(t[2] - t[1]), 64'(N + 2));
    end

    // random operands and ops
    for (int i = 0; i < 24; i++) begin
      do_op($urandom, 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
